// File: rtl/oam_write_scheduler.sv
// oam_write_scheduler: buffers CPU sprite writes in a small FIFO and commits
// them to OAM only during vertical blanking. PPU reads always win the port.
module oam_write_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int VBLANK_START = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  vCount,
    input  logic        cpu_wr,
    input  logic [5:0]  cpu_addr,
    input  logic [31:0] cpu_data,
    output logic        cpu_ready,
    input  logic        ppu_rd,
    input  logic [5:0]  ppu_addr,
    output logic        oam_we,
    output logic [5:0]  oam_addr,
    output logic [31:0] oam_wdata,
    output logic        ppu_grant,
    output logic        vblank,
    output logic        frame_end,
    output logic [4:0]  pending,
    output logic        overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ACTIVE, VBL_IDLE, VBL_DRAIN} state_t;

    logic [5:0]  addr_mem [FIFO_DEPTH];
    logic [31:0] data_mem [FIFO_DEPTH];

    state_t      state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]  count_q, count_d;
    logic        vblank_q, vblank_d;
    logic        frame_end_q, frame_end_d;
    logic        overflow_q, overflow_d;
    logic        oam_we_q, oam_we_d;
    logic [5:0]  oam_addr_q, oam_addr_d;
    logic [31:0] oam_wdata_q, oam_wdata_d;
    logic        ppu_grant_q, ppu_grant_d;

    logic full, empty, push, pop, drain_ok;

    // Next-state logic: FIFO bookkeeping, blanking flag, FSM and OAM port mux
    always_comb begin
        full     = (count_q == 5'(FIFO_DEPTH));
        empty    = (count_q == 5'd0);
        push     = cpu_wr && !full;
        // Any blanking state may issue a write as soon as an entry exists, so
        // the first strobe follows the IDLE entry by one edge rather than two.
        drain_ok = (state_q != ACTIVE) && vblank_q && !empty;
        pop      = drain_ok && !ppu_rd;

        count_d  = count_q + {4'd0, push} - {4'd0, pop};
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        vblank_d    = ({22'd0, vCount} >= 32'(VBLANK_START));
        frame_end_d = vblank_d && !vblank_q;
        overflow_d  = overflow_q || (cpu_wr && full);

        state_d = state_q;
        case (state_q)
            ACTIVE:    if (vblank_q) state_d = VBL_IDLE;
            VBL_IDLE:  if (!vblank_q) state_d = ACTIVE;
                       else if (count_d != 5'd0) state_d = VBL_DRAIN;
            VBL_DRAIN: if (!vblank_q) state_d = ACTIVE;
                       else if (count_d == 5'd0) state_d = VBL_IDLE;
            default:   state_d = ACTIVE;
        endcase

        oam_we_d    = 1'b0;
        ppu_grant_d = 1'b0;
        oam_addr_d  = oam_addr_q;
        oam_wdata_d = oam_wdata_q;
        if (ppu_rd) begin
            // PPU read stalls any pending drain; the head entry stays queued
            oam_addr_d  = ppu_addr;
            ppu_grant_d = 1'b1;
        end else if (drain_ok) begin
            oam_we_d    = 1'b1;
            oam_addr_d  = addr_mem[rd_ptr_q];
            oam_wdata_d = data_mem[rd_ptr_q];
        end
    end

    // FIFO storage; contents are don't-care until a push, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= cpu_addr;
            data_mem[wr_ptr_q] <= cpu_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACTIVE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            vblank_q    <= 1'b0;
            frame_end_q <= 1'b0;
            overflow_q  <= 1'b0;
            oam_we_q    <= 1'b0;
            oam_addr_q  <= '0;
            oam_wdata_q <= '0;
            ppu_grant_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            vblank_q    <= vblank_d;
            frame_end_q <= frame_end_d;
            overflow_q  <= overflow_d;
            oam_we_q    <= oam_we_d;
            oam_addr_q  <= oam_addr_d;
            oam_wdata_q <= oam_wdata_d;
            ppu_grant_q <= ppu_grant_d;
        end
    end

    assign cpu_ready = (count_q != 5'(FIFO_DEPTH));
    assign pending   = count_q;
    assign vblank    = vblank_q;
    assign frame_end = frame_end_q;
    assign overflow  = overflow_q;
    assign oam_we    = oam_we_q;
    assign oam_addr  = oam_addr_q;
    assign oam_wdata = oam_wdata_q;
    assign ppu_grant = ppu_grant_q;
endmodule

// File: tb/tb_oam_write_scheduler.sv
// Scoreboard bench for oam_write_scheduler: expected OAM writes are queued
// as CPU writes are issued; a negedge monitor pops and compares each strobe.
module tb_oam_write_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  vCount = '0;
    logic        cpu_wr = 1'b0;
    logic [5:0]  cpu_addr = '0;
    logic [31:0] cpu_data = '0;
    logic        ppu_rd = 1'b0;
    logic [5:0]  ppu_addr = '0;
    logic        cpu_ready, oam_we, ppu_grant, vblank, frame_end, overflow;
    logic [5:0]  oam_addr;
    logic [31:0] oam_wdata;
    logic [4:0]  pending;

    oam_write_scheduler #(.FIFO_DEPTH(4), .VBLANK_START(480)) dut (
        .clk(clk), .rst(rst), .vCount(vCount),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_ready(cpu_ready), .ppu_rd(ppu_rd), .ppu_addr(ppu_addr),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
        .ppu_grant(ppu_grant), .vblank(vblank), .frame_end(frame_end),
        .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int wr_seen = 0;
    int ws;
    logic [37:0] exp_q[$];
    logic [37:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [31:0] d, input bit keep);
        cpu_wr = 1'b1; cpu_addr = a; cpu_data = d;
        if (keep) exp_q.push_back({a, d});
        tick();
        cpu_wr = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && oam_we) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", oam_addr, oam_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(oam_addr), 32'(mon_e[37:32]));
                chk("wr_data", oam_wdata, mon_e[31:0]);
            end
        end
    end

    initial begin
        repeat (2) tick();
        chk("rst_pending", 32'(pending), 0);
        chk("rst_ready", 32'(cpu_ready), 1);
        chk("rst_we", 32'(oam_we), 0);
        chk("rst_addr", 32'(oam_addr), 0);
        chk("rst_grant", 32'(ppu_grant), 0);
        chk("rst_vblank", 32'(vblank), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        vCount = 10'd100;
        tick();

        // Writes held during active video, then drained at blanking start
        push_wr(6'd5, 32'hA5A5_0001, 1);
        push_wr(6'd6, 32'hA5A5_0002, 1);
        push_wr(6'd7, 32'hA5A5_0003, 1);
        repeat (2) tick();
        chk("hold_we", 32'(oam_we), 0);
        chk("hold_pending", 32'(pending), 3);
        vCount = 10'd480;
        tick();
        chk("vbl_rise", 32'(vblank), 1);
        chk("frame_end_hi", 32'(frame_end), 1);
        chk("n0_we", 32'(oam_we), 0);
        tick();
        chk("n1_we", 32'(oam_we), 0);
        chk("frame_end_lo", 32'(frame_end), 0);
        tick(); chk("n2_we", 32'(oam_we), 1); chk("n2_addr", 32'(oam_addr), 5);
        tick(); chk("n3_we", 32'(oam_we), 1); chk("n3_addr", 32'(oam_addr), 6);
        tick(); chk("n4_we", 32'(oam_we), 1); chk("n4_addr", 32'(oam_addr), 7);
        tick();
        chk("n5_we", 32'(oam_we), 0);
        chk("drained", 32'(pending), 0);
        vCount = 10'd0;
        repeat (2) tick();
        chk("vbl_fall", 32'(vblank), 0);

        // Overflow: fifth write while full is dropped
        for (int i = 0; i < 5; i++)
            push_wr(6'(10 + i), 32'h1000 + 32'(i), i < 4);
        chk("full_pending", 32'(pending), 4);
        chk("full_ready", 32'(cpu_ready), 0);
        chk("ovf_set", 32'(overflow), 1);
        vCount = 10'd480;
        repeat (8) tick();
        chk("ovf_drained", 32'(pending), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ready_again", 32'(cpu_ready), 1);
        vCount = 10'd0;
        repeat (2) tick();

        // PPU read stalls the drain for two cycles
        push_wr(6'd20, 32'h0000_00B0, 1);
        push_wr(6'd21, 32'h0000_00B1, 1);
        vCount = 10'd480;
        repeat (2) tick();
        ppu_rd = 1'b1; ppu_addr = 6'h3F;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("ppu_grant", 32'(ppu_grant), 1);
            chk("ppu_addr", 32'(oam_addr), 32'h3F);
            chk("ppu_we", 32'(oam_we), 0);
            chk("ppu_pending", 32'(pending), 2);
        end
        ppu_rd = 1'b0;
        tick(); chk("res_we0", 32'(oam_we), 1); chk("res_addr0", 32'(oam_addr), 20); chk("res_grant", 32'(ppu_grant), 0);
        tick(); chk("res_we1", 32'(oam_we), 1); chk("res_addr1", 32'(oam_addr), 21);
        tick(); chk("res_done", 32'(pending), 0); chk("res_we2", 32'(oam_we), 0);
        vCount = 10'd0;
        repeat (2) tick();

        // Blanking ends after two commits; rest waits for the next blanking
        for (int i = 0; i < 4; i++)
            push_wr(6'(30 + i), 32'hC000_0000 + 32'(i), 1);
        ws = wr_seen;
        vCount = 10'd480;
        repeat (3) tick();
        vCount = 10'd0;
        repeat (5) tick();
        chk("midend_writes", 32'(wr_seen - ws), 2);
        chk("midend_pending", 32'(pending), 2);
        chk("midend_we", 32'(oam_we), 0);
        vCount = 10'd480;
        repeat (6) tick();
        chk("next_vbl_drained", 32'(pending), 0);
        vCount = 10'd0;
        repeat (2) tick();

        // Reset asserted asynchronously after the first commit of a drain
        for (int i = 0; i < 3; i++)
            push_wr(6'(40 + i), 32'hD000_0000 + 32'(i), 1);
        vCount = 10'd480;
        repeat (3) tick();
        #5;
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(oam_we), 0);
        chk("arst_pending", 32'(pending), 0);
        chk("arst_ready", 32'(cpu_ready), 1);
        chk("arst_addr", 32'(oam_addr), 0);
        chk("arst_wdata", oam_wdata, 0);
        chk("arst_vblank", 32'(vblank), 0);
        chk("arst_flushed", 32'(exp_q.size()), 2);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        ws = wr_seen;
        repeat (6) tick();
        chk("post_rst_writes", 32'(wr_seen - ws), 0);
        chk("post_rst_pending", 32'(pending), 0);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/oam_write_scheduler.md
# oam_write_scheduler

Arbitrates access to the sprite OAM between CPU write requests and PPU read requests. CPU writes (`cpu_wr`, `cpu_addr`, `cpu_data`) are buffered in a small FIFO and committed to OAM only during vertical blanking, one entry per cycle. PPU reads always take priority. The block sits between the CPU bus and the PPU's OAM port, clocked on the PPU clock, and uses `vCount` from `vga_controller` to detect blanking.

## Interface
Parameters:
- `FIFO_DEPTH`, 4 — CPU write buffer entries; power of two, 2..16.
- `VBLANK_START`, 480 — first `vCount` value treated as vertical blanking.

Ports:
- `clk` in 1 — PPU clock; the only clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `vCount` in 10 — current VGA line from `vga_controller`.
- `cpu_wr` in 1 — CPU write request; accepted on a rising `clk` edge when `cpu_ready`=1.
- `cpu_addr` in 6 — OAM entry index (64 sprites).
- `cpu_data` in 32 — sprite entry data.
- `cpu_ready` out 1 — FIFO not full.
- `ppu_rd` in 1 — PPU read request (sprite evaluation).
- `ppu_addr` in 6 — PPU read index.
- `oam_we` out 1 — OAM write strobe.
- `oam_addr` out 6 — OAM address (write or read).
- `oam_wdata` out 32 — OAM write data.
- `ppu_grant` out 1 — `oam_addr` currently carries `ppu_addr`.
- `vblank` out 1 — registered blanking flag.
- `frame_end` out 1 — one-cycle pulse on `vblank` rising.
- `pending` out 5 — FIFO occupancy, 0..`FIFO_DEPTH`.
- `overflow` out 1 — sticky: a write was attempted while the FIFO was full.

## Operation
- FIFO: circular buffer of {addr, data}. Push happens when `cpu_wr`=1 and not full. Pop happens on each committed OAM write. Entries are written in strict arrival order. Repeated writes to the same address are all committed, in order.
- `cpu_wr` while full: the data is dropped, `overflow` is set to 1, and the FIFO is unchanged. `overflow` is cleared only by `rst`.
- Simultaneous push and pop: both take effect and `pending` is unchanged. A push is gated only by the pre-edge full state; there is no pass-through when full.
- `cpu_ready` = (`pending` != `FIFO_DEPTH`), combinational from registered count.
- `vblank` is registered as (`vCount` >= `VBLANK_START`). `frame_end` is registered as `vblank_next` & !`vblank`.
- State machine, evaluated each edge using the registered `vblank`:
  - ACTIVE (`vblank`=0): no writes are issued. Goes to VBL_IDLE when `vblank` becomes 1.
  - VBL_IDLE: goes to VBL_DRAIN when the FIFO is non-empty. Goes to ACTIVE when `vblank`=0.
  - VBL_DRAIN: each edge with `ppu_rd`=0 issues one write and pops. Goes to VBL_IDLE when the FIFO becomes empty. Goes to ACTIVE when `vblank`=0; undrained entries persist to the next blanking.
- Address mux, registered, in priority order:
  1. `ppu_rd`=1: `oam_addr`<=`ppu_addr`, `ppu_grant`<=1, `oam_we`<=0. This holds in every state, and a drain write is stalled (not lost).
  2. Draining with an entry: `oam_we`<=1, `oam_addr`/`oam_wdata`<=head, pop.
  3. Otherwise: `oam_we`<=0, `ppu_grant`<=0, and `oam_addr`/`oam_wdata` hold their values.
- Reset values: state ACTIVE, FIFO empty, `pending`=0, `cpu_ready`=1, `oam_we`=0, `oam_addr`=0, `oam_wdata`=0, `ppu_grant`=0, `vblank`=0, `frame_end`=0, `overflow`=0. A reset asserted mid-drain discards all pending entries, and no further `oam_we` occurs.

## Timing
- Push at edge N: entry is visible at head after N. If draining, the earliest pop is at edge N+1, with `oam_we`=1 during cycle N+1..N+2.
- `vCount` crossing `VBLANK_START` at edge N: `vblank`=1 after N, the state leaves ACTIVE at N+1, and the first write strobe is high after N+2.
- `vblank` falling: the strobe issued at that same edge is the last one, and no `oam_we` appears after the edge where `vblank`=0 is sampled.
- Throughput: one OAM write per cycle while draining with `ppu_rd`=0.
- `ppu_rd` → `ppu_grant`/`oam_addr` latency is 1 cycle, with no wait states.
- `pending` wraps correctly across pointer wrap-around at `FIFO_DEPTH`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs at reset values immediately; `cpu_ready`=1, `pending`=0.
- Hold during active video: 3 writes at `vCount`=100 (addr 5,6,7; data 0xA5A5_0001..3) → `oam_we` stays 0 and `pending`=3. Step `vCount` to 480 → three consecutive `oam_we` pulses with addr 5,6,7 in order starting 2 cycles after the crossing, then `pending`=0; `frame_end` pulses once.
- Full/overflow with `FIFO_DEPTH`=4 in active video: 5 write attempts → `pending`=4, `cpu_ready`=0, `overflow`=1, fifth entry absent from the drain.
- PPU priority: during drain with 2 entries, assert `ppu_rd` with `ppu_addr`=0x3F for 2 cycles → `ppu_grant`=1 and `oam_addr`=0x3F for 2 cycles with no `oam_we`; the drain then resumes with both entries written.
- Blanking ends mid-drain: 4 entries, `vCount` returns to 0 after 2 commits → exactly 2 writes and `pending`=2; the remaining 2 are written in the next blanking interval.
- Reset mid-drain: 3 entries, `rst` after first commit → no further `oam_we`; `pending`=0 after release.
